// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM and a
// small receive FIFO drained through a valid/ready handshake.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 48_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  logic              rx_meta_q, rx_s_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              push_req;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic [7:0]        data_q, data_d;
  logic              pop, full, push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d        = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    pop       = rx_ready && (count_q != '0);
    full      = (count_q == FIFO_FULL);
    push_ok   = push_req && (!full || pop);
    overrun_d = push_req && full && !pop;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    data_d = (count_d != '0) ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      mem_q       <= mem_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = (count_q != '0);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default rates: single byte, back-to-back,
// backpressure/overrun, framing error with break, glitch rejection, mid-byte reset.
module tb_uart_rx;

  localparam int unsigned CPB = 416;
  localparam int unsigned HB  = 208;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ  (48_000_000),
    .BAUD_RATE (115_200),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  int unsigned checks = 0;
  int unsigned fails  = 0;

  logic [7:0]  pops[$];
  int unsigned valid_cyc = 0, fe_cnt = 0, ov_cnt = 0, busy_cyc = 0, long_cnt = 0;
  logic        fe_prev = 1'b0, ov_prev = 1'b0;

  // Inputs only change just after a rising edge, so what is seen here is what
  // the next rising edge acts on.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) pops.push_back(rx_data);
    if (rx_valid)  valid_cyc <= valid_cyc + 1;
    if (frame_err) fe_cnt    <= fe_cnt + 1;
    if (overrun)   ov_cnt    <= ov_cnt + 1;
    if (rx_busy)   busy_cyc  <= busy_cyc + 1;
    if ((frame_err && fe_prev) || (overrun && ov_prev)) long_cnt <= long_cnt + 1;
    fe_prev <= frame_err;
    ov_prev <= overrun;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pop_at(input int unsigned idx);
    if (idx < pops.size()) return pops[idx];
    return 8'hxx;
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line is left at the stop-bit level so a low stop bit can run into a break.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  int unsigned pb, fb, ob, vb, bb;
  logic [7:0]  seq [5];

  initial begin
    tick(2);
    chk("reset_rx_valid",  {31'd0, rx_valid},  32'd0);
    chk("reset_rx_data",   {24'd0, rx_data},   32'd0);
    chk("reset_rx_busy",   {31'd0, rx_busy},   32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_overrun",   {31'd0, overrun},   32'd0);
    rst = 1'b0;
    tick(CPB);

    // single byte
    rx_ready = 1'b1;
    pb = pops.size(); vb = valid_cyc; fb = fe_cnt;
    send_frame(8'h55, 1'b1);
    tick(8);
    chk("single_pops",        pops.size() - pb, 32'd1);
    chk("single_data",        {24'd0, pop_at(pb)}, 32'h55);
    chk("single_valid_cyc",   valid_cyc - vb, 32'd1);
    chk("single_frame_err",   fe_cnt - fb, 32'd0);
    chk("single_busy_after",  {31'd0, rx_busy}, 32'd0);

    // back-to-back
    pb = pops.size(); fb = fe_cnt; ob = ov_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(8);
    chk("b2b_pops",      pops.size() - pb, 32'd2);
    chk("b2b_first",     {24'd0, pop_at(pb)},     32'h00);
    chk("b2b_second",    {24'd0, pop_at(pb + 1)}, 32'hFF);
    chk("b2b_errors",    (fe_cnt - fb) + (ov_cnt - ob), 32'd0);

    // backpressure and overrun
    rx_ready = 1'b0;
    pb = pops.size(); ob = ov_cnt; fb = fe_cnt;
    send_frame(8'h01, 1'b1);
    chk("bp_valid_first", {31'd0, rx_valid}, 32'd1);
    chk("bp_head_first",  {24'd0, rx_data},  32'h01);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    chk("bp_no_ovr_at_4", ov_cnt - ob, 32'd0);
    send_frame(8'h05, 1'b1);
    chk("bp_ovr_at_5",    ov_cnt - ob, 32'd1);
    chk("bp_head_full",   {24'd0, rx_data}, 32'h01);
    // single-cycle ready lands on the 0x06 stop-sample edge (start + 3954 edges)
    fork
      send_frame(8'h06, 1'b1);
      begin
        tick(3954);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    chk("full_pushpop_ovr",  ov_cnt - ob, 32'd1);
    chk("full_pushpop_pops", pops.size() - pb, 32'd1);
    chk("full_pushpop_valid", {31'd0, rx_valid}, 32'd1);
    chk("full_pushpop_head", {24'd0, rx_data}, 32'h02);
    rx_ready = 1'b1;
    tick(8);
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04; seq[4] = 8'h06;
    chk("drain_pops", pops.size() - pb, 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("drain_byte%0d", i), {24'd0, pop_at(pb + i)}, {24'd0, seq[i]});
    chk("drain_valid_low", {31'd0, rx_valid}, 32'd0);
    chk("drain_frame_err", fe_cnt - fb, 32'd0);

    // framing error followed by a 20-bit break
    pb = pops.size(); fb = fe_cnt; vb = valid_cyc;
    send_frame(8'hA5, 1'b0);
    tick(20 * CPB);
    rx = 1'b1;
    tick(CPB);
    chk("ferr_pulses", fe_cnt - fb, 32'd1);
    chk("ferr_no_pop", pops.size() - pb, 32'd0);
    chk("ferr_no_valid", valid_cyc - vb, 32'd0);
    chk("ferr_busy_idle", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h3C, 1'b1);
    tick(8);
    chk("ferr_next_pops", pops.size() - pb, 32'd1);
    chk("ferr_next_data", {24'd0, pop_at(pb)}, 32'h3C);
    chk("ferr_next_no_err", fe_cnt - fb, 32'd1);

    // glitch
    pb = pops.size(); fb = fe_cnt; bb = busy_cyc; vb = valid_cyc;
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    tick(2 * HB);
    chk("glitch_busy_seen",  {31'd0, (busy_cyc - bb) != 0},        32'd1);
    chk("glitch_busy_bound", {31'd0, (busy_cyc - bb) <= HB + 3},   32'd1);
    chk("glitch_busy_now",   {31'd0, rx_busy}, 32'd0);
    chk("glitch_no_valid",   valid_cyc - vb, 32'd0);
    chk("glitch_no_ferr",    fe_cnt - fb, 32'd0);

    // reset during data bit 3 with two bytes buffered
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("rst_pre_valid", {31'd0, rx_valid}, 32'd1);
    chk("rst_pre_head",  {24'd0, rx_data},  32'h11);
    pb = pops.size(); fb = fe_cnt;
    fork
      send_frame(8'hF8, 1'b1);
      begin
        tick(1800);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_busy",  {31'd0, rx_busy},  32'd0);
        chk("rst_data",  {24'd0, rx_data},  32'd0);
      end
    join
    tick(CPB);
    rx_ready = 1'b1;
    tick(4);
    chk("rst_fifo_empty", pops.size() - pb, 32'd0);
    send_frame(8'hC3, 1'b1);
    tick(8);
    chk("rst_next_pops", pops.size() - pb, 32'd1);
    chk("rst_next_data", {24'd0, pop_at(pb)}, 32'hC3);
    chk("rst_no_ferr",   fe_cnt - fb, 32'd0);

    chk("pulse_width", long_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
